// File: rtl/sgpr_replay_ctrl_if.sv
// Signal bundle between the replay controller, the core write-back stage,
// the shadow GPR file and the core register file write port.
interface sgpr_replay_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic                  replay_req_i;
  logic                  core_we_i;
  logic [ADDR_WIDTH-1:0] core_waddr_i;
  logic [DATA_WIDTH-1:0] core_wdata_i;
  logic                  sgpr_we_o;
  logic [ADDR_WIDTH-1:0] sgpr_waddr_o;
  logic [DATA_WIDTH-1:0] sgpr_wdata_o;
  logic [ADDR_WIDTH-1:0] sgpr_raddr_o;
  logic [DATA_WIDTH-1:0] sgpr_rdata_i;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0] rf_wdata_o;
  logic                  halt_core_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  overrun_o;
  logic [CNT_WIDTH-1:0]  replay_cnt_o;

  // Environment side: drives requests, write-back traffic and shadow read data.
  modport master (
    output replay_req_i, core_we_i, core_waddr_i, core_wdata_i, sgpr_rdata_i,
    input  sgpr_we_o, sgpr_waddr_o, sgpr_wdata_o, sgpr_raddr_o,
           rf_we_o, rf_waddr_o, rf_wdata_o,
           halt_core_o, busy_o, done_o, overrun_o, replay_cnt_o
  );

  // Controller side.
  modport slave (
    input  replay_req_i, core_we_i, core_waddr_i, core_wdata_i, sgpr_rdata_i,
    output sgpr_we_o, sgpr_waddr_o, sgpr_wdata_o, sgpr_raddr_o,
           rf_we_o, rf_waddr_o, rf_wdata_o,
           halt_core_o, busy_o, done_o, overrun_o, replay_cnt_o
  );
endinterface

// File: rtl/sgpr_replay_ctrl.sv
// Shadow-GPR replay sequencer: mirrors core write-back into the shadow file,
// and on a fault halts the core and copies shadow entries back into the core RF.
module sgpr_replay_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 31,
  parameter int CNT_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  sgpr_replay_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HALT, COPY, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0]  replay_cnt;
  logic                  overrun;
  logic                  idle_q;
  logic                  halt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  copy_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Decode flags are registered alongside the state so outputs never glitch
  // on state transitions; they always equal the decode of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= FIRST_IDX;
      replay_cnt <= '0;
      overrun    <= 1'b0;
      idle_q     <= 1'b1;
      halt_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      copy_q     <= 1'b0;
    end else begin
      if (state != IDLE && bus.replay_req_i) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.replay_req_i) begin
            state      <= HALT;
            replay_cnt <= sat_inc(replay_cnt);
            idle_q     <= 1'b0;
            halt_q     <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        HALT: begin
          state  <= COPY;
          idx    <= FIRST_IDX;
          copy_q <= 1'b1;
        end
        COPY: begin
          // Terminate by compare so LAST_REG at the top of the address space never wraps.
          if (idx == LAST_IDX) begin
            state  <= DONE;
            copy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx <= idx + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          halt_q <= 1'b0;
          busy_q <= 1'b0;
          idle_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          idle_q <= 1'b1;
          halt_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          copy_q <= 1'b0;
        end
      endcase
    end
  end

  // Write-back pass-through only while idle; x0 is never shadowed.
  assign bus.sgpr_we_o    = idle_q && bus.core_we_i && (bus.core_waddr_i != '0);
  assign bus.sgpr_waddr_o = idle_q ? bus.core_waddr_i : '0;
  assign bus.sgpr_wdata_o = idle_q ? bus.core_wdata_i : '0;

  assign bus.sgpr_raddr_o = copy_q ? idx : '0;
  assign bus.rf_we_o      = copy_q;
  assign bus.rf_waddr_o   = copy_q ? idx : '0;
  assign bus.rf_wdata_o   = copy_q ? bus.sgpr_rdata_i : '0;

  assign bus.halt_core_o  = halt_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.overrun_o    = overrun;
  assign bus.replay_cnt_o = replay_cnt;

endmodule

// File: tb/tb_sgpr_replay_ctrl.sv
// Randomized scoreboard bench for sgpr_replay_ctrl with a cycle-phase reference model.
module tb_sgpr_replay_ctrl;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int FR   = 1;
  localparam int LR   = 31;
  localparam int CW   = 2;
  localparam int NREG = LR - FR + 1;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    bit            chk;
    bit            sgpr_we;
    logic [AW-1:0] sgpr_waddr;
    logic [DW-1:0] sgpr_wdata;
    logic [AW-1:0] sgpr_raddr;
    bit            rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    bit            halt;
    bit            busy;
    bit            done;
    bit            overrun;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;

  sgpr_replay_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  sgpr_replay_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIRST_REG(FR), .LAST_REG(LR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment shadow file, written only through the controller's write port.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  assign bus.sgpr_rdata_i = env_mem[bus.sgpr_raddr_o];
  always @(posedge clk) begin
    if (bus.sgpr_we_o) env_mem[bus.sgpr_waddr_o] <= bus.sgpr_wdata_o;
  end

  // Reference model: what the shadow file should hold, and where we are in a replay.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int   phase;      // 0 = idle, 1 = halt, 2..NREG+1 = copy, NREG+2 = done
  int   m_cnt;
  bit   m_overrun;
  int   cyc;
  int   checks;
  int   failures;
  exp_t exp_q [$];
  exp_t mon_e;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  function automatic exp_t model_expect(input bit r, input bit we, input int addr, input logic [DW-1:0] data);
    exp_t e;
    int   a;
    e.chk = !r;
    e.sgpr_we = 1'b0; e.sgpr_waddr = '0; e.sgpr_wdata = '0; e.sgpr_raddr = '0;
    e.rf_we = 1'b0; e.rf_waddr = '0; e.rf_wdata = '0;
    e.halt = (phase != 0); e.busy = (phase != 0); e.done = (phase == NREG + 2);
    e.overrun = m_overrun; e.cnt = CW'(m_cnt);
    if (phase == 0) begin
      e.sgpr_we    = we && (addr != 0);
      e.sgpr_waddr = AW'(addr);
      e.sgpr_wdata = data;
    end else if (phase >= 2 && phase <= NREG + 1) begin
      a = FR + phase - 2;
      e.sgpr_raddr = AW'(a);
      e.rf_we      = 1'b1;
      e.rf_waddr   = AW'(a);
      e.rf_wdata   = ref_mem[a];
    end
    return e;
  endfunction

  task automatic model_advance(input bit r, input bit req, input bit we, input int addr, input logic [DW-1:0] data);
    if (r) begin
      phase = 0; m_cnt = 0; m_overrun = 1'b0;
    end else if (phase == 0) begin
      if (we && addr != 0) ref_mem[addr] = data;
      if (req) begin
        phase = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end else begin
      if (req) m_overrun = 1'b1;
      phase++;
      if (phase > NREG + 2) phase = 0;
    end
  endtask

  task automatic step(input bit r, input bit req, input bit we, input int addr, input logic [DW-1:0] data);
    @(posedge clk); #1;
    cyc++;
    rst              = r;
    bus.replay_req_i = req;
    bus.core_we_i    = we;
    bus.core_waddr_i = AW'(addr);
    bus.core_wdata_i = data;
    exp_q.push_back(model_expect(r, we, addr, data));
    model_advance(r, req, we, addr, data);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  // Monitor: pops one expectation per cycle and compares away from the clock edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk) begin
        cmp("sgpr_we", 64'(bus.sgpr_we_o), 64'(mon_e.sgpr_we));
        if (mon_e.sgpr_we) begin
          cmp("sgpr_waddr", 64'(bus.sgpr_waddr_o), 64'(mon_e.sgpr_waddr));
          cmp("sgpr_wdata", 64'(bus.sgpr_wdata_o), 64'(mon_e.sgpr_wdata));
        end
        cmp("sgpr_raddr", 64'(bus.sgpr_raddr_o), 64'(mon_e.sgpr_raddr));
        cmp("rf_we",      64'(bus.rf_we_o),      64'(mon_e.rf_we));
        cmp("rf_waddr",   64'(bus.rf_waddr_o),   64'(mon_e.rf_waddr));
        cmp("rf_wdata",   64'(bus.rf_wdata_o),   64'(mon_e.rf_wdata));
        cmp("halt_core",  64'(bus.halt_core_o),  64'(mon_e.halt));
        cmp("busy",       64'(bus.busy_o),       64'(mon_e.busy));
        cmp("done",       64'(bus.done_o),       64'(mon_e.done));
        cmp("overrun",    64'(bus.overrun_o),    64'(mon_e.overrun));
        cmp("replay_cnt", 64'(bus.replay_cnt_o), 64'(mon_e.cnt));
      end
    end
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    phase = 0; m_cnt = 0; m_overrun = 1'b0;
    for (int k = 0; k < (1 << AW); k++) begin
      env_mem[k] = '0;
      ref_mem[k] = '0;
    end
    rst = 1'b1;
    bus.replay_req_i = 1'b0; bus.core_we_i = 1'b0;
    bus.core_waddr_i = '0;   bus.core_wdata_i = '0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 0, '0);
    idle(2);

    // Fill the shadow file with 3*i, plus an x0 write that must be suppressed.
    for (int i = 1; i <= 31; i++) step(1'b0, 1'b0, 1'b1, i, DW'(3 * i));
    step(1'b0, 1'b0, 1'b1, 0, 32'hDEAD_BEEF);
    idle(2);

    // Single-cycle replay request.
    step(1'b0, 1'b1, 1'b0, 0, '0);
    idle(40);

    // Request together with a core write to reg 10.
    step(1'b0, 1'b1, 1'b1, 10, 32'd100);
    idle(40);

    // Second request mid-copy: ignored, sets overrun.
    step(1'b0, 1'b1, 1'b0, 0, '0);
    idle(15);
    step(1'b0, 1'b1, 1'b0, 0, '0);
    idle(30);

    // Reset during the 10th copy cycle, then a full replay.
    step(1'b0, 1'b1, 1'b0, 0, '0);
    idle(10);
    step(1'b1, 1'b0, 1'b0, 0, '0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 0, '0);
    idle(40);

    // Random traffic with sparse requests; writes during a replay are dropped.
    for (int k = 0; k < 400; k++) begin
      step(1'b0, ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, (1 << AW) - 1)), DW'($urandom));
    end
    idle(40);

    // Request held high: back-to-back replays, counter saturates.
    for (int k = 0; k < 100; k++) step(1'b0, 1'b1, 1'b0, 0, '0);
    idle(40);

    @(negedge clk); #1;
    cmp("queue_drain", 64'(exp_q.size()), 64'd0);
    cmp("final_cnt", 64'(bus.replay_cnt_o), 64'(CMAX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sgpr_replay_ctrl.md
Name: sgpr_replay_ctrl

Overview:
Sequencer that restores the core register file from the shadow GPR (sgpr) copy after a detected fault.
- In normal operation it forwards core write-back traffic into the shadow file and suppresses writes to x0.
- On a replay request it halts the core, freezes the shadow file, then walks registers FIRST_REG..LAST_REG. Each cycle it reads one shadow entry and writes it into the core register file.
- It sits between the core write-back stage, the sgpr block and the core register file's write port.

Parameters:
ADDR_WIDTH, 5, register address width.
DATA_WIDTH, 32, register data width.
FIRST_REG, 1, first restored register (x0 is never restored).
LAST_REG, 31, last restored register; must satisfy FIRST_REG <= LAST_REG < 2**ADDR_WIDTH.
CNT_WIDTH, 8, width of the replay event counter.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
replay_req_i  in  1  fault detected; sampled each cycle, level or pulse.
core_we_i  in  1  core write-back enable.
core_waddr_i  in  ADDR_WIDTH  core write-back address.
core_wdata_i  in  DATA_WIDTH  core write-back data.
sgpr_we_o  out  1  shadow file write enable.
sgpr_waddr_o  out  ADDR_WIDTH  shadow file write address.
sgpr_wdata_o  out  DATA_WIDTH  shadow file write data.
sgpr_raddr_o  out  ADDR_WIDTH  shadow file read address.
sgpr_rdata_i  in  DATA_WIDTH  shadow file read data; combinational, same cycle.
rf_we_o  out  1  core register file restore write enable.
rf_waddr_o  out  ADDR_WIDTH  restore address.
rf_wdata_o  out  DATA_WIDTH  restore data.
halt_core_o  out  1  stall the core pipeline.
busy_o  out  1  replay in progress.
done_o  out  1  one-cycle pulse when the restore completes.
overrun_o  out  1  sticky: a replay request arrived while busy.
replay_cnt_o  out  CNT_WIDTH  number of replays started, saturating.

Behaviour:
- FSM states: IDLE, HALT, COPY, DONE; state held in a register.
- Reset: state=IDLE, idx=FIRST_REG, replay_cnt=0, overrun=0.
  - All outputs are 0 during and after reset, except pass-through values in IDLE.
  - Reset mid-replay aborts immediately; a partially restored core file is left as is.
- IDLE:
  - sgpr_we_o = core_we_i && (core_waddr_i != 0); sgpr_waddr_o and sgpr_wdata_o mirror the core inputs combinationally.
  - rf_we_o=0, halt_core_o=0, busy_o=0.
  - If replay_req_i=1: next state HALT, replay_cnt += 1 (saturates at all-ones).
  - A core write in the same cycle as the request is still committed to sgpr.
- HALT (1 cycle): halt_core_o=1, busy_o=1, sgpr_we_o=0, idx loaded with FIRST_REG; next state COPY. This cycle lets in-flight write-back quiesce.
- COPY:
  - halt_core_o=1, busy_o=1, sgpr_we_o=0.
  - sgpr_raddr_o=idx, rf_we_o=1, rf_waddr_o=idx, rf_wdata_o=sgpr_rdata_i.
  - idx increments each cycle. When idx==LAST_REG, the write for that cycle completes and the next state is DONE.
  - COPY lasts LAST_REG-FIRST_REG+1 cycles.
- DONE (1 cycle): done_o=1, halt_core_o=1, busy_o=1, rf_we_o=0; next state IDLE. The core resumes the cycle after DONE.
- Timing: request sampled at edge N gives HALT in cycle N+1, COPY in N+2..N+32 (defaults), DONE in N+33, IDLE in N+34.
- Outside COPY, sgpr_raddr_o=0.
- replay_req_i while in HALT, COPY or DONE: ignored (not queued), overrun_o set to 1. overrun_o is cleared only by rst.
- replay_req_i held high across DONE→IDLE: a new replay starts from IDLE, giving back-to-back replays with replay_cnt incremented each time.
- Core writes presented while not in IDLE are dropped; the core is halted, so none are expected.
- idx never wraps: the LAST_REG=2**ADDR_WIDTH-1 case terminates by comparison, not overflow.

Test Plan:
- Reset, then core writes reg i with data 3*i for i=1..31, plus a write to addr 0 → sgpr_we_o=1 for i=1..31 with matching addr and data; sgpr_we_o=0 for the addr 0 write; rf_we_o=0 throughout.
- Single-cycle replay_req_i at cycle N → halt_core_o=1 from N+1 to N+33; rf_we_o=1 for exactly 31 cycles (N+2..N+32) with rf_waddr_o=1..31 and rf_wdata_o=3*addr; done_o=1 only at N+33; replay_cnt_o=1.
- replay_req_i together with core write (addr 10, data 100) in the same cycle → sgpr write committed; restore of reg 10 delivers 100.
- replay_req_i pulsed mid-COPY → no restart, sequence unchanged, overrun_o=1 and stays 1; replay_cnt_o unchanged.
- rst asserted in the 10th COPY cycle → next cycle IDLE, all outputs 0, replay_cnt_o=0; a new replay then runs the full 31-cycle sequence.
- replay_req_i held high for 100 cycles → back-to-back replays separated by one IDLE cycle; replay_cnt_o=3 (CNT_WIDTH=2 build saturates at 3 after 3 or more replays).
